// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
// Optional parity support is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

   localparam int unsigned DEF_CLK_FREQ = 50_000_000;
   localparam int unsigned DEF_BAUD     = 115200;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;
`endif

   // Clocks per oversample tick, rounded to nearest
   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned baud,
                                            input int unsigned os);
      int unsigned denom;
      denom = baud * os;
      return (clk_freq + denom / 2) / denom;
   endfunction

   // 2-of-3 majority vote
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receive-side byte handshake and status flags of the UART receiver.
// With UART_RX_PARITY_EN defined the bundle carries a parity_err pulse.
interface uart_rx_os_if #(
   parameter int unsigned DATA_BITS = 8
) ();
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 overrun;
`ifdef UART_RX_PARITY_EN
   logic                 parity_err;

   modport master (output rx_data, output rx_valid, output frame_err,
                   output overrun, output parity_err, input rx_ready);
   modport slave  (input rx_data, input rx_valid, input frame_err,
                   input overrun, input parity_err, output rx_ready);
`else
   modport master (output rx_data, output rx_valid, output frame_err,
                   output overrun, input rx_ready);
   modport slave  (input rx_data, input rx_valid, input frame_err,
                   input overrun, output rx_ready);
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every DIV clocks.
module uart_baud_tick #(
   parameter int unsigned DIV = 27
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   // Wrap the counter at DIV-1 and flag the wrap
   always_comb begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
      if (cnt_q == CW'(DIV - 1)) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   // Divider state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;
endmodule

// File: rtl/uart_rx_os.sv
// UART receiver with oversampling and 3-sample majority vote at bit centre.
// Delivers bytes on a valid/ready handshake, flags framing errors and overrun.
// Define UART_RX_PARITY_EN to add a parity bit (even unless PARITY_ODD=1).
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
   parameter int unsigned BAUD       = DEF_BAUD,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit          PARITY_ODD = 1'b0
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rxd,
   uart_rx_os_if.master rx_if
);
   localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int unsigned TW  = $clog2(OVERSAMPLE);
   localparam int unsigned BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   logic tick;

   rx_state_e            state_q, state_d;
   logic                 sync1_q, sync2_q;
   logic [1:0]           hist_q, hist_d;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 armed_q, armed_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_acc_q, par_acc_d;
   logic                 parity_err_q, parity_err_d;
`endif

   logic rxs_c;
   logic vote_c;
   logic at_mid_c;
   logic at_last_c;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Bring the asynchronous line into the clock domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
      end
   end

   assign rxs_c     = sync2_q;
   assign vote_c    = maj3(hist_q[1], hist_q[0], rxs_c);
   assign at_mid_c  = tick && (tick_cnt_q == TICK_MID);
   assign at_last_c = tick && (tick_cnt_q == TICK_LAST);

   // Next-state and datapath for the receive FSM
   always_comb begin
      state_d     = state_q;
      hist_d      = hist_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      armed_d     = armed_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q & ~rx_if.rx_ready;
      frame_err_d = 1'b0;
      overrun_d   = overrun_q;
`ifdef UART_RX_PARITY_EN
      par_acc_d    = par_acc_q;
      parity_err_d = 1'b0;
`endif

      if (tick) begin
         hist_d = {hist_q[0], rxs_c};
         if (state_q != ST_IDLE) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
         end
      end

      case (state_q)
         ST_IDLE: begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            if (rxs_c) begin
               armed_d = 1'b1;
            end
            if (tick && !rxs_c && armed_q) begin
               state_d = ST_START;
            end
         end

         ST_START: begin
            if (at_mid_c && vote_c) begin
               state_d = ST_IDLE;
            end else if (at_last_c) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
               par_acc_d = 1'b0;
`endif
            end
         end

         ST_DATA: begin
            if (at_mid_c) begin
               shreg_d = {vote_c, shreg_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
               par_acc_d = par_acc_q ^ vote_c;
`endif
            end
            if (at_last_c) begin
               if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (at_mid_c) begin
               parity_err_d = par_acc_q ^ vote_c ^ PARITY_ODD;
            end
            if (at_last_c) begin
               state_d = ST_STOP;
            end
         end
`endif

         ST_STOP: begin
            // Leave at bit centre so a following start edge is never missed
            if (at_mid_c) begin
               state_d = ST_IDLE;
               if (vote_c) begin
                  if (rx_valid_q && !rx_if.rx_ready) begin
                     overrun_d = 1'b1;
                  end else begin
                     rx_data_d  = shreg_q;
                     rx_valid_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  armed_d     = 1'b0;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Receive FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hist_q      <= 2'b11;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         armed_q     <= 1'b1;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_acc_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         hist_q      <= hist_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         armed_q     <= armed_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_acc_q    <= par_acc_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign rx_if.rx_data   = rx_data_q;
   assign rx_if.rx_valid  = rx_valid_q;
   assign rx_if.frame_err = frame_err_q;
   assign rx_if.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign rx_if.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at default parameters (1 bit = 432 clk).
// Also covers the parity build when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os;
   import uart_pkg::*;

   localparam int BIT_CLKS = 432;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int LAT_LO = (FRAME_BITS - 1) * BIT_CLKS + 112;
   localparam int LAT_HI = (FRAME_BITS - 1) * BIT_CLKS + 368;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd = 1'b1;

   int checks   = 0;
   int failures = 0;

   int cyc      = 0;
   int rises    = 0;
   int ferr_n   = 0;
   int perr_n   = 0;
   int rise_cyc = 0;
   logic prev_valid = 1'b0;
   logic [7:0] hist [64];

   uart_rx_os_if #(.DATA_BITS(8)) rx_if ();

   uart_rx_os #(
      .CLK_FREQ   (50_000_000),
      .BAUD       (115200),
      .OVERSAMPLE (16),
      .DATA_BITS  (8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .rxd   (rxd),
      .rx_if (rx_if)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe outputs on the falling edge: new bytes, error pulse widths
   always @(negedge clk) begin
      if (rx_if.rx_valid && !prev_valid) begin
         hist[rises[5:0]] <= rx_if.rx_data;
         rises            <= rises + 1;
         rise_cyc         <= cyc;
      end
      prev_valid <= rx_if.rx_valid;
      if (rx_if.frame_err) ferr_n <= ferr_n + 1;
`ifdef UART_RX_PARITY_EN
      if (rx_if.parity_err) perr_n <= perr_n + 1;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input int bclk, input logic bad_par);
      rxd = 1'b0;
      wait_clks(bclk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         wait_clks(bclk);
      end
`ifdef UART_RX_PARITY_EN
      rxd = (^b) ^ bad_par;
      wait_clks(bclk);
`else
      if (bad_par) rxd = 1'b1;
`endif
      rxd = stop_bit;
      wait_clks(bclk);
      rxd = 1'b1;
   endtask

   initial begin
      int r0;
      int f0;
      int t0;
      int idx;
      int skew [2];
      logic [7:0] c3;
      logic [7:0] exp3 [3];

      skew[0] = 445;
      skew[1] = 419;
      exp3[0] = 8'h00;
      exp3[1] = 8'hFF;
      exp3[2] = 8'h81;
      c3      = 8'hC3;

      rx_if.rx_ready = 1'b1;
      rst = 1'b1;
      wait_clks(5);
      @(negedge clk);
      chk("rst_valid", 32'(rx_if.rx_valid), 32'd0);
      chk("rst_data", 32'(rx_if.rx_data), 32'd0);
      chk("rst_ferr", 32'(rx_if.frame_err), 32'd0);
      chk("rst_ovr", 32'(rx_if.overrun), 32'd0);
      chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      rst = 1'b0;
      wait_clks(500);

      // 1: plain byte and latency
      r0 = rises; f0 = ferr_n; t0 = cyc;
      send_frame(8'h55, 1'b1, BIT_CLKS, 1'b0);
      wait_clks(BIT_CLKS);
      chk("t1_rises", 32'(rises - r0), 32'd1);
      chk("t1_data", 32'(hist[r0[5:0]]), 32'h55);
      chk("t1_ferr", 32'(ferr_n - f0), 32'd0);
      chk("t1_lat_lo", 32'(rise_cyc - t0 >= LAT_LO), 32'd1);
      chk("t1_lat_hi", 32'(rise_cyc - t0 <= LAT_HI), 32'd1);
      chk("t1_consumed", 32'(rx_if.rx_valid), 32'd0);

      // 2: short glitch rejected, next byte fine
      r0 = rises;
      rxd = 1'b0;
      wait_clks(130);
      rxd = 1'b1;
      wait_clks(2 * BIT_CLKS);
      chk("t2_glitch_rises", 32'(rises - r0), 32'd0);
      chk("t2_glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
      send_frame(8'hA3, 1'b1, BIT_CLKS, 1'b0);
      wait_clks(BIT_CLKS);
      chk("t2_rises", 32'(rises - r0), 32'd1);
      chk("t2_data", 32'(hist[r0[5:0]]), 32'hA3);

      // 3: bad stop bit, then a break
      r0 = rises; f0 = ferr_n;
      send_frame(8'h0F, 1'b0, BIT_CLKS, 1'b0);
      wait_clks(2 * BIT_CLKS);
      chk("t3_ferr", 32'(ferr_n - f0), 32'd1);
      chk("t3_rises", 32'(rises - r0), 32'd0);
      f0 = ferr_n;
      rxd = 1'b0;
      wait_clks(3 * FRAME_BITS * BIT_CLKS);
      chk("t3_break_mid", 32'(ferr_n - f0), 32'd1);
      rxd = 1'b1;
      wait_clks(2 * BIT_CLKS);
      chk("t3_break_end", 32'(ferr_n - f0), 32'd1);
      chk("t3_break_rises", 32'(rises - r0), 32'd0);

      // 4: overrun keeps the old byte, handshake clears valid next cycle
      @(negedge clk);
      rx_if.rx_ready = 1'b0;
      r0 = rises;
      send_frame(8'h11, 1'b1, BIT_CLKS, 1'b0);
      send_frame(8'h22, 1'b1, BIT_CLKS, 1'b0);
      wait_clks(BIT_CLKS);
      @(negedge clk);
      chk("t4_valid", 32'(rx_if.rx_valid), 32'd1);
      chk("t4_data", 32'(rx_if.rx_data), 32'h11);
      chk("t4_ovr", 32'(rx_if.overrun), 32'd1);
      chk("t4_rises", 32'(rises - r0), 32'd1);
      rx_if.rx_ready = 1'b1;
      @(negedge clk);
      chk("t4_valid_drop", 32'(rx_if.rx_valid), 32'd0);
      chk("t4_ovr_sticky", 32'(rx_if.overrun), 32'd1);

      // 5: reset in the middle of a frame
      rxd = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rxd = c3[i];
         wait_clks(BIT_CLKS);
      end
      rxd = c3[4];
      wait_clks(BIT_CLKS / 2);
      @(negedge clk);
      rst = 1'b1;
      #2;
      chk("t5_valid", 32'(rx_if.rx_valid), 32'd0);
      chk("t5_data", 32'(rx_if.rx_data), 32'd0);
      chk("t5_ovr", 32'(rx_if.overrun), 32'd0);
      chk("t5_ferr", 32'(rx_if.frame_err), 32'd0);
      chk("t5_state", 32'(dut.state_q), 32'(ST_IDLE));
      rxd = 1'b1;
      wait_clks(10);
      @(negedge clk);
      rst = 1'b0;
      wait_clks(2 * BIT_CLKS);
      r0 = rises;
      send_frame(8'h3C, 1'b1, BIT_CLKS, 1'b0);
      wait_clks(BIT_CLKS);
      chk("t5_rises", 32'(rises - r0), 32'd1);
      chk("t5_next", 32'(hist[r0[5:0]]), 32'h3C);
      chk("t5_ovr_after", 32'(rx_if.overrun), 32'd0);

      // 6: back-to-back frames with +/-3% rate skew
      for (int s = 0; s < 2; s++) begin
         r0 = rises; f0 = ferr_n;
         for (int k = 0; k < 3; k++) begin
            send_frame(exp3[k], 1'b1, skew[s], 1'b0);
         end
         wait_clks(BIT_CLKS);
         chk("t6_rises", 32'(rises - r0), 32'd3);
         chk("t6_ferr", 32'(ferr_n - f0), 32'd0);
         for (int k = 0; k < 3; k++) begin
            idx = r0 + k;
            chk("t6_data", 32'(hist[idx[5:0]]), 32'(exp3[k]));
         end
      end
      chk("t6_perr_none", 32'(perr_n), 32'd0);

`ifdef UART_RX_PARITY_EN
      r0 = rises; f0 = perr_n;
      send_frame(8'h81, 1'b1, BIT_CLKS, 1'b1);
      wait_clks(BIT_CLKS);
      chk("t6_perr", 32'(perr_n - f0), 32'd1);
      chk("t6_perr_rises", 32'(rises - r0), 32'd1);
      chk("t6_perr_data", 32'(hist[r0[5:0]]), 32'h81);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
